axi3_write_path: RTL and testbench

- Self-contained AXI3 write path: a write master, a write slave and a 128x32 memory, all on one clock.
- A device pushes data words into the master with `memoryWrite` strobes.
- The master launches one AXI3 burst over the AW/W/B channels. The slave writes each beat into the memory and returns a write response.
- A side read port lets a bench inspect memory contents.

---
 rtl/axi3_write_path.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi3_write_path.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/axi3_write_path.sv
// rtl/axi3_write_path.sv - AXI3 write master, write slave and 128x32 memory on one clock
// Optional WID-vs-AWID checking in the slave: define AXI_WID_CHECK_EN.
module axi3_write_path #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 128,
  parameter int BUF_DEPTH = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              memoryWrite,
  input  logic [DATA_W-1:0] Datain,
  input  logic [31:0]       WADDR,
  input  logic [3:0]        ID,
  input  logic [3:0]        WWID,
  input  logic [3:0]        WLEN,
  input  logic [2:0]        WSIZE,
  input  logic [1:0]        WBURST,
  input  logic [1:0]        WLOCK,
  input  logic [3:0]        WCACHE,
  input  logic [2:0]        WPROT,
  input  logic              cs,
  input  logic [6:0]        readaddy,
  output logic [DATA_W-1:0] readdata,
  output logic [1:0]        response,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {M_IDLE, M_ADDR, M_DATA, M_RESP} m_state_t;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_WAIT, S_RESP} s_state_t;

  m_state_t          m_state;
  s_state_t          s_state;

  logic              mw_q;
  logic [4:0]        count;
  logic [DATA_W-1:0] buffer [BUF_DEPTH];
  logic              capture;

  logic              awvalid, awready;
  logic [31:0]       awaddr;
  logic [3:0]        awid, awlen, awcache;
  logic [2:0]        awsize, awprot;
  logic [1:0]        awburst, awlock;
  logic              wvalid, wready, wlast;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wid, wstrb, beat;
  logic              bvalid, bready;
  logic [3:0]        bid;
  logic [1:0]        bresp;

  logic [3:0]        s_awid, s_awlen;
  logic [1:0]        s_burst;
  logic [6:0]        idx, addressout;
  logic [DATA_W-1:0] dataout;
  logic              writeavail, finishwrite, last_q, slverr;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Only the rising edge of the device strobe counts, and only while the master is idle.
  assign capture = memoryWrite && !mw_q && !busy && (count < 5'(BUF_DEPTH));
  assign wdata   = buffer[beat];
  assign wstrb   = 4'hF;

  always_ff @(posedge ACLK) begin
    if (capture)
      buffer[count[3:0]] <= Datain;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      m_state  <= M_IDLE;
      mw_q     <= 1'b0;
      count    <= '0;
      awvalid  <= 1'b0;
      awaddr   <= '0;
      awid     <= '0;
      awlen    <= '0;
      awsize   <= '0;
      awburst  <= '0;
      awlock   <= '0;
      awcache  <= '0;
      awprot   <= '0;
      wid      <= '0;
      wvalid   <= 1'b0;
      wlast    <= 1'b0;
      beat     <= '0;
      bready   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      response <= 2'b00;
    end else begin
      mw_q <= memoryWrite;
      done <= 1'b0;
      if (capture)
        count <= count + 5'd1;
      case (m_state)
        M_IDLE: begin
          if (count == ({1'b0, WLEN} + 5'd1)) begin
            awaddr  <= WADDR;
            awid    <= ID;
            awlen   <= WLEN;
            awsize  <= WSIZE;
            awburst <= WBURST;
            awlock  <= WLOCK;
            awcache <= WCACHE;
            awprot  <= WPROT;
            wid     <= WWID;
            awvalid <= 1'b1;
            busy    <= 1'b1;
            m_state <= M_ADDR;
          end
        end
        M_ADDR: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            beat    <= '0;
            wlast   <= (awlen == 4'd0);
            m_state <= M_DATA;
          end
        end
        M_DATA: begin
          if (wvalid && wready) begin
            if (wlast) begin
              wvalid  <= 1'b0;
              wlast   <= 1'b0;
              bready  <= 1'b1;
              m_state <= M_RESP;
            end else begin
              beat  <= beat + 4'd1;
              wlast <= ((beat + 4'd1) == awlen);
            end
          end
        end
        M_RESP: begin
          if (bvalid && bready) begin
            response <= bresp;
            done     <= 1'b1;
            bready   <= 1'b0;
            busy     <= 1'b0;
            count    <= '0;
            m_state  <= M_IDLE;
          end
        end
        default: m_state <= M_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      s_state    <= S_IDLE;
      awready    <= 1'b0;
      s_awid     <= '0;
      s_awlen    <= '0;
      s_burst    <= '0;
      idx        <= '0;
      wready     <= 1'b0;
      addressout <= '0;
      dataout    <= '0;
      writeavail <= 1'b0;
      last_q     <= 1'b0;
      slverr     <= 1'b0;
      bvalid     <= 1'b0;
      bid        <= '0;
      bresp      <= 2'b00;
    end else begin
      writeavail <= 1'b0;
      case (s_state)
        S_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready <= 1'b0;
            s_awid  <= awid;
            s_awlen <= awlen;
            s_burst <= awburst;
            idx     <= awaddr[8:2];
            slverr  <= (awburst == 2'b11);
            wready  <= 1'b1;
            s_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (wvalid && wready) begin
            wready     <= 1'b0;
            addressout <= idx;
            dataout    <= wdata;
            writeavail <= 1'b1;
            last_q     <= wlast;
`ifdef AXI_WID_CHECK_EN
            if (wid != s_awid)
              slverr <= 1'b1;
`endif
            s_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (finishwrite) begin
            // FIXED holds the word index; every other burst type steps by one word, wrapping at 127.
            if (s_burst != 2'b00)
              idx <= idx + 7'd1;
            if (last_q) begin
              bvalid  <= 1'b1;
              bid     <= s_awid;
              bresp   <= slverr ? 2'b10 : 2'b00;
              s_state <= S_RESP;
            end else begin
              wready  <= 1'b1;
              s_state <= S_DATA;
            end
          end
        end
        S_RESP: begin
          if (bvalid && bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            s_state <= S_IDLE;
          end
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (cs && writeavail)
      mem[addressout] <= dataout;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn)
      finishwrite <= 1'b0;
    else
      finishwrite <= cs && writeavail;
  end

  assign readdata = cs ? mem[readaddy] : '0;

  logic unused_sigs;
`ifdef AXI_WID_CHECK_EN
  assign unused_sigs = ^{awaddr[31:9], awaddr[1:0], awsize, awlock, awcache, awprot,
                         wstrb, bid, s_awlen};
`else
  assign unused_sigs = ^{awaddr[31:9], awaddr[1:0], awsize, awlock, awcache, awprot,
                         wstrb, bid, s_awlen, wid};
`endif

endmodule

// File: tb/tb_axi3_write_path.sv
// tb/tb_axi3_write_path.sv - scoreboard bench for axi3_write_path
module tb_axi3_write_path;

  logic        clk = 1'b0;
  logic        resetn;
  logic        memoryWrite;
  logic [31:0] Datain, WADDR;
  logic [3:0]  ID, WWID, WLEN, WCACHE;
  logic [2:0]  WSIZE, WPROT;
  logic [1:0]  WBURST, WLOCK;
  logic        cs;
  logic [6:0]  readaddy;
  logic [31:0] readdata;
  logic [1:0]  response;
  logic        done, busy;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t      exp_beats[$];
  logic [1:0] exp_resp[$];
  int         pass_cnt = 0;
  int         total    = 0;
  int         aw_hs    = 0;

  always #5 clk = ~clk;

  axi3_write_path dut (
    .ACLK(clk), .ARESETn(resetn), .memoryWrite(memoryWrite), .Datain(Datain),
    .WADDR(WADDR), .ID(ID), .WWID(WWID), .WLEN(WLEN), .WSIZE(WSIZE),
    .WBURST(WBURST), .WLOCK(WLOCK), .WCACHE(WCACHE), .WPROT(WPROT),
    .cs(cs), .readaddy(readaddy), .readdata(readdata), .response(response),
    .done(done), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows a W handshake or a done pulse.
  always @(negedge clk) begin
    if (resetn) begin
      if (dut.awvalid && dut.awready) aw_hs++;
      if (dut.wvalid && dut.wready) begin
        if (exp_beats.size() == 0) check("w_unexpected", 32'd1, 32'd0);
        else begin
          beat_t b;
          b = exp_beats.pop_front();
          check("wdata", dut.wdata, b.data);
          check("wlast", {31'd0, dut.wlast}, {31'd0, b.last});
        end
      end
      if (done) begin
        if (exp_resp.size() == 0) check("done_unexpected", 32'd1, 32'd0);
        else check("bresp", {30'd0, response}, {30'd0, exp_resp.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [31:0] d);
    Datain = d; memoryWrite = 1'b1; tick();
    memoryWrite = 1'b0; tick();
  endtask

  task automatic issue(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                       input logic [3:0] id, input logic [3:0] wwid, input logic [1:0] resp,
                       input logic [31:0] base, input int npulse);
    WADDR = addr; WLEN = len; WBURST = burst; ID = id; WWID = wwid;
    for (int i = 0; i <= int'(len); i++) begin
      beat_t b;
      b.data = base + 32'(i);
      b.last = (i == int'(len));
      exp_beats.push_back(b);
    end
    exp_resp.push_back(resp);
    for (int i = 0; i < npulse; i++) pulse(base + 32'(i));
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    #1;
  endtask

  task automatic rd(input logic [6:0] a, input logic [31:0] exp, input string name);
    readaddy = a; #1;
    check(name, readdata, exp);
  endtask

  initial begin
    int hs0;
    resetn = 1'b0; memoryWrite = 1'b0; Datain = '0; WADDR = '0; ID = '0; WWID = '0;
    WLEN = 4'd3; WSIZE = 3'd2; WBURST = 2'b01; WLOCK = '0; WCACHE = '0; WPROT = '0;
    cs = 1'b1; readaddy = '0;
    tick(); tick();
    Datain = 32'h55; memoryWrite = 1'b1; tick();
    memoryWrite = 1'b0; tick();
    resetn = 1'b1;
    @(negedge clk);
    check("rst_response", {30'd0, response}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_valids", {29'd0, dut.awvalid, dut.wvalid, dut.bvalid}, 32'd0);
    check("rst_count", {27'd0, dut.count}, 32'd0);
    #1;

    // INCR burst of 4 at word 2
    hs0 = aw_hs;
    issue(32'h8, 4'd3, 2'b01, 4'd1, 4'd1, 2'b00, 32'd1, 4);
    wait_done();
    check("incr_aw_count", aw_hs - hs0, 32'd1);
    rd(7'd2, 32'd1, "mem2"); rd(7'd3, 32'd2, "mem3");
    rd(7'd4, 32'd3, "mem4"); rd(7'd5, 32'd4, "mem5");
    cs = 1'b0; rd(7'd2, 32'd0, "cs_low_read"); cs = 1'b1;

    // FIXED burst lands every beat on word 2
    issue(32'h8, 4'd3, 2'b00, 4'd1, 4'd1, 2'b00, 32'h11, 4);
    wait_done();
    rd(7'd2, 32'h14, "fixed_mem2"); rd(7'd3, 32'd2, "fixed_mem3");

    // Reserved burst type: SLVERR but the word is written
    issue(32'h40, 4'd0, 2'b11, 4'd1, 4'd1, 2'b10, 32'hDEAD, 1);
    wait_done();
    rd(7'd16, 32'hDEAD, "slverr_mem16");

    // Partial fill holds the master idle; the 4th word launches a burst wrapping at 127
    hs0 = aw_hs;
    issue(32'h1FC, 4'd3, 2'b01, 4'd1, 4'd1, 2'b00, 32'hA0, 3);
    repeat (10) tick();
    check("partial_busy", {31'd0, busy}, 32'd0);
    check("partial_awvalid", {31'd0, dut.awvalid}, 32'd0);
    check("partial_aw_count", aw_hs - hs0, 32'd0);
    pulse(32'hA3);
    wait_done();
    rd(7'd127, 32'hA0, "wrap_mem127"); rd(7'd0, 32'hA1, "wrap_mem0");
    rd(7'd1, 32'hA2, "wrap_mem1"); rd(7'd2, 32'hA3, "wrap_mem2");

`ifdef AXI_WID_CHECK_EN
    issue(32'h80, 4'd0, 2'b01, 4'd1, 4'd2, 2'b10, 32'hB0, 1);
`else
    issue(32'h80, 4'd0, 2'b01, 4'd1, 4'd2, 2'b00, 32'hB0, 1);
`endif
    wait_done();
    issue(32'h84, 4'd0, 2'b01, 4'd1, 4'd1, 2'b00, 32'hB1, 1);
    wait_done();
    rd(7'd32, 32'hB0, "wid_mem32"); rd(7'd33, 32'hB1, "wid_mem33");

    check("beats_drained", exp_beats.size(), 32'd0);
    check("resps_drained", exp_resp.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
